key_input_conditioner: RTL

- Upstream stage of the keyboard GUI: turns raw, bouncy push-button levels into clean, debounced, active-high key levels.
- Emits one-cycle press/release pulses per key.
- Raises a req/ack redraw request carrying a stable key snapshot. The GUI control FSM consumes the snapshot as its keys input and redraws on request.

---
 rtl/gui_pkg.sv | 23 ++
 rtl/key_debounce_channel.sv | 68 ++++++
 rtl/key_input_conditioner.sv | 93 +++++++++
 3 files changed

// File: rtl/gui_pkg.sv
// Shared definitions for the keyboard GUI front end: key indices, the
// request-FSM state encoding and the idle ("released") raw pin level.
package gui_pkg;

  localparam int NUM_KEYS_DEF = 4;

  localparam int KEY_C0 = 0;
  localparam int KEY_C1 = 1;
  localparam int KEY_C2 = 2;
  localparam int KEY_C3 = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_GAP  = 2'b10
  } req_state_e;

  // Raw pin level of a button that is not pressed.
  function automatic logic released_level(input bit raw_active_low);
    return raw_active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: 2-flop synchronizer, polarity normalisation, debounce
// counter, accepted level and one-cycle press/release pulses.
module key_debounce_channel
  import gui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic key_o,
  output logic down_o,
  output logic up_o
);

  localparam logic             REL_LEVEL = released_level(RAW_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             pressed;
  logic             differ, accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q, key_d;
  logic             down_q, down_d;
  logic             up_q, up_d;

  assign pressed = (RAW_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  // The counter only runs while the synchronized level disagrees with the
  // accepted one, so it can never pass CNT_LAST and any agreeing cycle
  // throws away a partially counted edge.
  always_comb begin
    differ = (pressed != key_q);
    accept = differ && (cnt_q == CNT_LAST);
    cnt_d  = '0;
    if (differ && !accept) begin
      cnt_d = cnt_q + 1'b1;
    end
    key_d  = accept ? pressed : key_q;
    down_d = accept &  pressed;
    up_d   = accept & ~pressed;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= REL_LEVEL;
      sync2_q <= REL_LEVEL;
      cnt_q   <= '0;
      key_q   <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      down_q  <= down_d;
      up_q    <= up_d;
    end
  end

  assign key_o  = key_q;
  assign down_o = down_q;
  assign up_o   = up_q;

endmodule

// File: rtl/key_input_conditioner.sv
// Debounces NUM_KEYS raw buttons and raises a req/ack redraw request that
// carries a frozen snapshot of the debounced key levels.
module key_input_conditioner
  import gui_pkg::*;
#(
  parameter int NUM_KEYS        = NUM_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] raw_keys,
  output logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_up,
  output logic                change_req,
  input  logic                change_ack,
  output logic [NUM_KEYS-1:0] key_snapshot
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .raw_i (raw_keys[i]),
      .key_o (keys[i]),
      .down_o(key_down[i]),
      .up_o  (key_up[i])
    );
  end

  req_state_e          state_q;
  logic                dirty_q;
  logic                req_q;
  logic [NUM_KEYS-1:0] snap_q;
  logic                chg;

  // A pulse on either edge marks the cycle in which keys first shows its new value.
  assign chg = |(key_down | key_up);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dirty_q <= 1'b0;
      req_q   <= 1'b0;
      snap_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (chg) begin
            snap_q  <= keys;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A change landing together with the ack is remembered for the GAP.
          if (chg) begin
            dirty_q <= 1'b1;
          end
          if (change_ack) begin
            req_q   <= 1'b0;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (dirty_q || chg) begin
            snap_q  <= keys;
            dirty_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          dirty_q <= 1'b0;
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign change_req   = req_q;
  assign key_snapshot = snap_q;

endmodule
